// File: rtl/id_pipe_stage.sv
// Decode stage: regfile read, EX/MEM forwarding, load-use/hazard stall, registered ID/EX payload.
// One cycle from accept to out_valid; holds payload while out_valid && !out_ready, stalls upstream on hazards.
module id_pipe_stage #(
  parameter int DW         = 32,
  parameter bit FWD_EN     = 1'b1,
  parameter bit SEXT_LOGIC = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   inst_i,
  output logic [4:0]    rf_raddr1_o,
  output logic [4:0]    rf_raddr2_o,
  input  logic [DW-1:0] rf_rdata1_i,
  input  logic [DW-1:0] rf_rdata2_i,
  input  logic          ex_we_i,
  input  logic [4:0]    ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          ex_is_load_i,
  input  logic          mem_we_i,
  input  logic [4:0]    mem_waddr_i,
  input  logic [DW-1:0] mem_wdata_i,
  input  logic          flush_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   pc_o,
  output logic [5:0]    opcode_o,
  output logic [5:0]    funct_o,
  output logic [4:0]    shamt_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [DW-1:0] store_data_o,
  output logic          we_o,
  output logic [4:0]    waddr_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  output logic          illegal_o,
  output logic [15:0]   stall_cnt_o
);

  localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign shamt  = inst_i[10:6];
  assign funct  = inst_i[5:0];
  assign imm    = inst_i[15:0];

  assign rf_raddr1_o = rs;
  assign rf_raddr2_o = rt;

  logic [DW-1:0] imm_sext, imm_zext, imm_lui, imm_ext;
  logic legal, use_rs, use_rt, is_ld, is_st, is_br;

  assign imm_sext = DW'($signed(imm));
  assign imm_zext = DW'(imm);
  assign imm_lui  = DW'($signed({imm, 16'h0000}));

  always_comb begin
    legal   = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_br   = 1'b0;
    imm_ext = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_SLL, FN_SRL: begin
            legal  = 1'b1;
            use_rt = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
            legal  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        legal   = 1'b1;
        use_rs  = 1'b1;
        imm_ext = SEXT_LOGIC ? imm_sext : imm_zext;
      end
      OP_LUI: begin
        legal   = 1'b1;
        imm_ext = imm_lui;
      end
      OP_ADDIU, OP_LW: begin
        legal   = 1'b1;
        use_rs  = 1'b1;
        is_ld   = (opcode == OP_LW);
        imm_ext = imm_sext;
      end
      OP_SW, OP_BEQ: begin
        legal   = 1'b1;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        is_st   = (opcode == OP_SW);
        is_br   = (opcode == OP_BEQ);
        imm_ext = imm_sext;
      end
      default: legal = 1'b0;
    endcase
  end

  // EX has priority over MEM because it carries the younger value.
  logic          ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic [DW-1:0] op_a, op_b;

  assign ex_hit_a  = ex_we_i && (ex_waddr_i == rs) && (rs != 5'd0);
  assign ex_hit_b  = ex_we_i && (ex_waddr_i == rt) && (rt != 5'd0);
  assign mem_hit_a = mem_we_i && (mem_waddr_i == rs) && (rs != 5'd0);
  assign mem_hit_b = mem_we_i && (mem_waddr_i == rt) && (rt != 5'd0);

  assign op_a = (rs == 5'd0) ? '0 :
                (FWD_EN && ex_hit_a) ? ex_wdata_i :
                mem_hit_a ? mem_wdata_i : rf_rdata1_i;
  assign op_b = (rt == 5'd0) ? '0 :
                (FWD_EN && ex_hit_b) ? ex_wdata_i :
                mem_hit_b ? mem_wdata_i : rf_rdata2_i;

  logic haz_a, haz_b, stall, accept;
  assign haz_a  = (ex_hit_a && (ex_is_load_i || !FWD_EN)) || (!FWD_EN && mem_hit_a);
  assign haz_b  = (ex_hit_b && (ex_is_load_i || !FWD_EN)) || (!FWD_EN && mem_hit_b);
  assign stall  = in_valid && ((use_rs && haz_a) || (use_rt && haz_b));

  assign in_ready = !rst && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  logic [4:0] waddr;
  assign waddr = (opcode == OP_R) ? rd : rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      pc_o         <= '0;
      opcode_o     <= '0;
      funct_o      <= '0;
      shamt_o      <= '0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      store_data_o <= '0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      mem_rd_o     <= 1'b0;
      mem_wr_o     <= 1'b0;
      illegal_o    <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      if (stall && !flush_i && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush_i) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        pc_o         <= pc_i;
        opcode_o     <= opcode;
        funct_o      <= funct;
        shamt_o      <= shamt;
        alu_a_o      <= op_a;
        // Only SW among the rt users takes the immediate as its B operand.
        alu_b_o      <= (use_rt && !is_st) ? op_b : imm_ext;
        store_data_o <= is_st ? op_b : '0;
        we_o         <= legal && !is_st && !is_br && (waddr != 5'd0);
        waddr_o      <= waddr;
        mem_rd_o     <= is_ld;
        mem_wr_o     <= is_st;
        illegal_o    <= !legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: default, no-forwarding and sign-extending-logic variants share stimulus.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, ex_we, ex_is_load, mem_we, flush, out_ready;
  logic [31:0] pc, inst, ex_wdata, mem_wdata;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] regs [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Per-instance outputs: a_ = FWD_EN=1, n_ = FWD_EN=0, s_ = SEXT_LOGIC=1.
  logic        a_in_ready, a_out_valid, a_we, a_mem_rd, a_mem_wr, a_illegal;
  logic [4:0]  a_ra1, a_ra2, a_shamt, a_waddr;
  logic [5:0]  a_opcode, a_funct;
  logic [31:0] a_pc, a_alu_a, a_alu_b, a_sd, a_rd1, a_rd2;
  logic [15:0] a_scnt;
  logic        n_in_ready, n_out_valid, n_we, n_mem_rd, n_mem_wr, n_illegal;
  logic [4:0]  n_ra1, n_ra2, n_shamt, n_waddr;
  logic [5:0]  n_opcode, n_funct;
  logic [31:0] n_pc, n_alu_a, n_alu_b, n_sd, n_rd1, n_rd2;
  logic [15:0] n_scnt;
  logic        s_in_ready, s_out_valid, s_we, s_mem_rd, s_mem_wr, s_illegal;
  logic [4:0]  s_ra1, s_ra2, s_shamt, s_waddr;
  logic [5:0]  s_opcode, s_funct;
  logic [31:0] s_pc, s_alu_a, s_alu_b, s_sd, s_rd1, s_rd2;
  logic [15:0] s_scnt;

  assign a_rd1 = regs[a_ra1];
  assign a_rd2 = regs[a_ra2];
  assign n_rd1 = regs[n_ra1];
  assign n_rd2 = regs[n_ra2];
  assign s_rd1 = regs[s_ra1];
  assign s_rd2 = regs[s_ra2];

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .pc_i(pc), .inst_i(inst),
    .rf_raddr1_o(a_ra1), .rf_raddr2_o(a_ra2), .rf_rdata1_i(a_rd1), .rf_rdata2_i(a_rd2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata), .flush_i(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .pc_o(a_pc), .opcode_o(a_opcode),
    .funct_o(a_funct), .shamt_o(a_shamt), .alu_a_o(a_alu_a), .alu_b_o(a_alu_b),
    .store_data_o(a_sd), .we_o(a_we), .waddr_o(a_waddr), .mem_rd_o(a_mem_rd),
    .mem_wr_o(a_mem_wr), .illegal_o(a_illegal), .stall_cnt_o(a_scnt)
  );

  id_pipe_stage #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .pc_i(pc), .inst_i(inst),
    .rf_raddr1_o(n_ra1), .rf_raddr2_o(n_ra2), .rf_rdata1_i(n_rd1), .rf_rdata2_i(n_rd2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata), .flush_i(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .pc_o(n_pc), .opcode_o(n_opcode),
    .funct_o(n_funct), .shamt_o(n_shamt), .alu_a_o(n_alu_a), .alu_b_o(n_alu_b),
    .store_data_o(n_sd), .we_o(n_we), .waddr_o(n_waddr), .mem_rd_o(n_mem_rd),
    .mem_wr_o(n_mem_wr), .illegal_o(n_illegal), .stall_cnt_o(n_scnt)
  );

  id_pipe_stage #(.SEXT_LOGIC(1'b1)) dut_sx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .pc_i(pc), .inst_i(inst),
    .rf_raddr1_o(s_ra1), .rf_raddr2_o(s_ra2), .rf_rdata1_i(s_rd1), .rf_rdata2_i(s_rd2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata), .flush_i(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .pc_o(s_pc), .opcode_o(s_opcode),
    .funct_o(s_funct), .shamt_o(s_shamt), .alu_a_o(s_alu_a), .alu_b_o(s_alu_b),
    .store_data_o(s_sd), .we_o(s_we), .waddr_o(s_waddr), .mem_rd_o(s_mem_rd),
    .mem_wr_o(s_mem_wr), .illegal_o(s_illegal), .stall_cnt_o(s_scnt)
  );

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    regs[0] = 32'h0;
    regs[1] = 32'h0000_00F0;
    regs[3] = 32'h0000_0033;
    regs[5] = 32'h0000_0005;
    regs[7] = 32'h0000_0077;

    rst = 1'b1; in_valid = 1'b0; pc = 32'h0; inst = 32'h0; flush = 1'b0; out_ready = 1'b1;
    ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0;
    #1;
    chk("rst_in_ready", a_in_ready, 1'b0);
    step();
    step();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_alu_a", a_alu_a, 32'h0);
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_stall_cnt", a_scnt, 16'h0);
    rst = 1'b0;

    // ORI r2,r1,0x8001
    in_valid = 1'b1; pc = 32'h100; inst = i_ins(6'h0D, 5'd1, 5'd2, 16'h8001);
    #1;
    chk("ori_in_ready", a_in_ready, 1'b1);
    step();
    chk("ori_out_valid", a_out_valid, 1'b1);
    chk("ori_alu_a", a_alu_a, 32'h0000_00F0);
    chk("ori_alu_b", a_alu_b, 32'h0000_8001);
    chk("ori_we", a_we, 1'b1);
    chk("ori_waddr", a_waddr, 5'd2);
    chk("ori_pc", a_pc, 32'h100);
    chk("ori_sext_alu_b", s_alu_b, 32'hFFFF_8001);

    // LW r3 in EX, ADDU r4,r3,r5 at input: load-use stall
    ex_we = 1'b1; ex_waddr = 5'd3; ex_is_load = 1'b1; ex_wdata = 32'hDEAD;
    pc = 32'h104; inst = r_ins(5'd3, 5'd5, 5'd4, 5'd0, 6'h21);
    #1;
    chk("lu_in_ready", a_in_ready, 1'b0);
    step();
    chk("lu_bubble", a_out_valid, 1'b0);
    chk("lu_stall_cnt", a_scnt, 16'd1);
    ex_we = 1'b0; ex_is_load = 1'b0; mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h55;
    #1;
    chk("lu_release_ready", a_in_ready, 1'b1);
    step();
    chk("lu_out_valid", a_out_valid, 1'b1);
    chk("lu_alu_a_mem", a_alu_a, 32'h55);
    chk("lu_alu_b_rf", a_alu_b, 32'h5);
    chk("lu_waddr", a_waddr, 5'd4);
    chk("lu_stall_cnt_hold", a_scnt, 16'd1);

    // EX and MEM both write r7: SUBU r1,r7,r7
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h11;
    mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h22;
    pc = 32'h108; inst = r_ins(5'd7, 5'd7, 5'd1, 5'd0, 6'h23);
    #1;
    chk("dbl_in_ready", a_in_ready, 1'b1);
    chk("dbl_nf_in_ready", n_in_ready, 1'b0);
    step();
    chk("dbl_alu_a", a_alu_a, 32'h11);
    chk("dbl_alu_b", a_alu_b, 32'h11);
    chk("dbl_funct", a_funct, 6'h23);
    ex_we = 1'b0;
    #1;
    chk("dbl_nf_mem_stall", n_in_ready, 1'b0);
    step();
    chk("mem_fwd_alu_a", a_alu_a, 32'h22);
    mem_we = 1'b0;
    #1;
    chk("dbl_nf_clear", n_in_ready, 1'b1);
    step();
    chk("nf_out_valid", n_out_valid, 1'b1);
    chk("nf_alu_a_rf", n_alu_a, 32'h77);
    chk("rf_alu_a", a_alu_a, 32'h77);

    // Downstream backpressure for three cycles
    out_ready = 1'b0; pc = 32'h10C; inst = i_ins(6'h09, 5'd0, 5'd9, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_valid", a_out_valid, 1'b1);
      chk("bp_in_ready", a_in_ready, 1'b0);
      chk("bp_alu_a", a_alu_a, 32'h77);
      chk("bp_pc", a_pc, 32'h108);
      chk("bp_waddr", a_waddr, 5'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_in_ready, 1'b1);
    step();
    chk("addiu_alu_a", a_alu_a, 32'h0);
    chk("addiu_alu_b", a_alu_b, 32'hFFFF_FFFF);
    chk("addiu_waddr", a_waddr, 5'd9);

    // Flush overrides an accept in the same cycle
    flush = 1'b1; pc = 32'h110; inst = i_ins(6'h0F, 5'd0, 5'd10, 16'h1234);
    step();
    chk("flush_out_valid", a_out_valid, 1'b0);
    flush = 1'b0;

    inst = 32'hFC00_0000;
    step();
    chk("ill_out_valid", a_out_valid, 1'b1);
    chk("ill_illegal", a_illegal, 1'b1);
    chk("ill_we", a_we, 1'b0);
    chk("ill_mem_rd", a_mem_rd, 1'b0);

    inst = i_ins(6'h2B, 5'd0, 5'd0, 16'h0004);  // SW r0,4(r0)
    step();
    chk("sw_we", a_we, 1'b0);
    chk("sw_mem_wr", a_mem_wr, 1'b1);
    chk("sw_alu_b", a_alu_b, 32'h4);
    chk("sw_store_data", a_sd, 32'h0);

    inst = i_ins(6'h23, 5'd1, 5'd6, 16'hFFFC);  // LW r6,-4(r1)
    step();
    chk("lw_mem_rd", a_mem_rd, 1'b1);
    chk("lw_waddr", a_waddr, 5'd6);
    chk("lw_alu_b", a_alu_b, 32'hFFFF_FFFC);

    inst = i_ins(6'h04, 5'd1, 5'd5, 16'h0010);  // BEQ r1,r5
    step();
    chk("beq_we", a_we, 1'b0);
    chk("beq_alu_b", a_alu_b, 32'h5);

    inst = i_ins(6'h0F, 5'd0, 5'd10, 16'h8000);  // LUI r10,0x8000
    step();
    chk("lui_alu_b", a_alu_b, 32'h8000_0000);
    chk("lui_we", a_we, 1'b1);

    // Stall under flush is not counted; reset mid-stall clears everything
    ex_we = 1'b1; ex_waddr = 5'd3; ex_is_load = 1'b1;
    inst = r_ins(5'd3, 5'd5, 5'd4, 5'd0, 6'h21);
    flush = 1'b1;
    step();
    chk("flush_stall_cnt", a_scnt, 16'd1);
    flush = 1'b0;
    #1;
    chk("stall_in_ready", a_in_ready, 1'b0);
    step();
    chk("stall_cnt_inc", a_scnt, 16'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", a_in_ready, 1'b0);
    step();
    chk("rst_mid_out_valid", a_out_valid, 1'b0);
    chk("rst_mid_stall_cnt", a_scnt, 16'd0);
    chk("rst_mid_alu_b", a_alu_b, 32'h0);
    chk("rst_mid_nf_stall_cnt", n_scnt, 16'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
